seri2pari_block_rx: RTL

Receive-side counterpart of the block parallel-to-serial sender. Samples a framed serial bit stream once per srclk: idle high, start bit 0, 8 data bits MSB first, stop bit 1. Assembles the bytes into an NBYTES-deep block buffer and flags the block complete. A downstream reader drains the buffer through a random-access read port and releases it with an acknowledge.

---
 rtl/seri2pari_pkg.sv | 18 +
 rtl/seri2pari_block_rx_deser.sv | 80 ++++++++
 rtl/seri2pari_block_rx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seri2pari_pkg.sv
// Shared types and framing constants for the serial block receiver.
package seri2pari_pkg;

    // Receive FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STOP  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Line levels and frame length (start + 8 data + stop).
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/seri2pari_block_rx_deser.sv
// Frame deserialiser: finds the start bit, shifts in the data bits MSB first
// and judges the stop bit. Emits single-cycle good/err strobes that are
// combinational in the cycle the stop bit is on the line, so the parent
// registers the byte on the same edge that samples the stop bit.
module rx_frame_deser
    import seri2pari_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              srclk,
    input  logic              reset,
    input  logic              inbit,
    output logic [DATA_W-1:0] rx_byte,
    output logic              rx_good,
    output logic              rx_err
);

    localparam int BC_W = $clog2(DATA_W) + 1;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;

    // State, bit counter and shift register; reset discards any partial byte.
    always_ff @(posedge srclk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_good   = 1'b0;
        rx_err    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (inbit == START_BIT) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                // LSB-side shift leaves the first data bit in the MSB.
                shift_d   = {shift_q[DATA_W-2:0], inbit};
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (inbit == STOP_BIT) begin
                    rx_good = 1'b1;
                    state_d = IDLE;
                end else begin
                    rx_err  = 1'b1;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Line must return to idle before a new start bit counts.
                if (inbit == IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/seri2pari_block_rx.sv
// Serial block receiver: deserialises framed bytes into an NBYTES-deep
// buffer, flags a full block, and lets a reader drain it by address and
// release it with block_ack.
module seri2pari_block_rx
    import seri2pari_pkg::*;
#(
    parameter int NBYTES = 10,
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(NBYTES + 1),
    parameter int ADDR_W = $clog2(NBYTES)
) (
    input  logic              srclk,
    input  logic              reset,
    input  logic              inbit,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              byte_valid,
    output logic [DATA_W-1:0] byte_data,
    output logic [CNT_W-1:0]  byte_count,
    output logic              block_valid,
    input  logic              block_ack,
    output logic              frame_err,
    output logic              overflow
);

    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NBYTES);
    localparam logic [ADDR_W:0]   RD_LIMIT = (ADDR_W + 1)'(NBYTES);

    logic [DATA_W-1:0] rx_byte;
    logic              rx_good;
    logic              rx_err;

    logic [DATA_W-1:0] buf_q [NBYTES];
    logic [DATA_W-1:0] buf_d [NBYTES];
    logic [DATA_W-1:0] byte_data_q, byte_data_d;
    logic [CNT_W-1:0]  byte_count_q, byte_count_d;
    logic              byte_valid_q, byte_valid_d;
    logic              block_valid_q, block_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;

    logic              ack_take;
    logic [CNT_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] wr_addr;

    rx_frame_deser #(
        .DATA_W (DATA_W)
    ) u_deser (
        .srclk   (srclk),
        .reset   (reset),
        .inbit   (inbit),
        .rx_byte (rx_byte),
        .rx_good (rx_good),
        .rx_err  (rx_err)
    );

    // Buffer, counters and status flags.
    always_ff @(posedge srclk) begin
        if (reset) begin
            for (int i = 0; i < NBYTES; i++) buf_q[i] <= '0;
            byte_data_q   <= '0;
            byte_count_q  <= '0;
            byte_valid_q  <= 1'b0;
            block_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NBYTES; i++) buf_q[i] <= buf_d[i];
            byte_data_q   <= byte_data_d;
            byte_count_q  <= byte_count_d;
            byte_valid_q  <= byte_valid_d;
            block_valid_q <= block_valid_d;
            frame_err_q   <= frame_err_d;
            overflow_q    <= overflow_d;
        end
    end

    // Store / drop / release decision. An ack on the stop-bit edge frees
    // the buffer first, so that byte lands at index 0 instead of overflowing.
    always_comb begin
        buf_d         = buf_q;
        byte_data_d   = byte_data_q;
        byte_count_d  = byte_count_q;
        byte_valid_d  = 1'b0;
        block_valid_d = block_valid_q;
        frame_err_d   = 1'b0;
        overflow_d    = overflow_q;

        ack_take = block_ack & block_valid_q;
        wr_idx   = ack_take ? '0 : byte_count_q;
        wr_addr  = wr_idx[ADDR_W-1:0];

        if (ack_take) begin
            block_valid_d = 1'b0;
            byte_count_d  = '0;
        end

        if (rx_good) begin
            if ((!block_valid_q || ack_take) && (wr_idx < FULL_CNT)) begin
                buf_d[wr_addr] = rx_byte;
                byte_data_d    = rx_byte;
                byte_count_d   = wr_idx + CNT_W'(1);
                byte_valid_d   = 1'b1;
                if (wr_idx + CNT_W'(1) == FULL_CNT) begin
                    block_valid_d = 1'b1;
                end
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (rx_err) begin
            frame_err_d = 1'b1;
        end
    end

    // Random-access read port; out-of-range addresses read as zero.
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < RD_LIMIT) begin
            rd_data = buf_q[rd_addr];
        end
    end

    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign byte_count  = byte_count_q;
    assign block_valid = block_valid_q;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;

endmodule
